// File: rtl/fifo_sync_mc_pkg.sv
// Shared types and helpers for the single-clock multi-channel FIFO.
// Holds the default geometry, the per-channel pointer/channel types and
// the occupancy/flag helpers used by every channel controller.
package fifo_sync_mc_pkg;

    localparam int unsigned FIFO_W  = 32;
    localparam int unsigned FIFO_N  = 16;
    localparam int unsigned FIFO_C  = 4;
    localparam int unsigned FIFO_AW = $clog2(FIFO_N);
    localparam int unsigned FIFO_CW = $clog2(FIFO_C);

    // Pointer carries one extra wrap bit above the address bits.
    typedef logic [FIFO_AW:0]   ptr_t;
    typedef logic [FIFO_CW-1:0] chan_t;

    typedef struct packed {
        logic empty;
        logic full;
        logic afull;
    } flags_t;

    // Occupancy is the modulo-2^(AW+1) pointer difference.
    function automatic ptr_t ptr_count(input ptr_t wptr, input ptr_t rptr);
        return ptr_t'(wptr - rptr);
    endfunction

    function automatic ptr_t ptr_step(input ptr_t ptr, input logic en);
        return ptr_t'(ptr + ptr_t'(en));
    endfunction

    function automatic flags_t calc_flags(input ptr_t count, input ptr_t thresh);
        flags_t f;
        f.empty = (count == '0);
        f.full  = (count == ptr_t'(FIFO_N));
        f.afull = (count >= thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo_sync_mc_ctrl.sv
// Per-channel controller: write/read pointers, occupancy, flags and
// sticky error bits for one logical queue.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push_hit_i          push addressed to this channel
//   pop_hit_i           pop addressed to this channel
//   flush_i             empty the queue and clear errors
//   afull_thresh_i      almost-full threshold
//   wr_en_o_c/rd_en_o_c accepted push/pop this cycle (combinational)
//   wr_addr_o_c/rd_addr_o_c in-channel storage addresses (combinational)
//   empty_o, full_o, afull_o, count_o, ovf_o, udf_o  registered status
module fifo_sync_mc_ctrl
    import fifo_sync_mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_hit_i,
    input  logic               pop_hit_i,
    input  logic               flush_i,
    input  ptr_t               afull_thresh_i,
    output logic               wr_en_o_c,
    output logic               rd_en_o_c,
    output logic [FIFO_AW-1:0] wr_addr_o_c,
    output logic [FIFO_AW-1:0] rd_addr_o_c,
    output logic               empty_o,
    output logic               full_o,
    output logic               afull_o,
    output ptr_t               count_o,
    output logic               ovf_o,
    output logic               udf_o
);

    ptr_t   wptr_q, wptr_d;
    ptr_t   rptr_q, rptr_d;
    ptr_t   count_q, count_d;
    flags_t flags_q, flags_d;
    logic   ovf_q, ovf_d;
    logic   udf_q, udf_d;

    // Acceptance uses the registered flags; next-state flags come from next pointers.
    always_comb begin
        wr_en_o_c = push_hit_i & ~flags_q.full;
        rd_en_o_c = pop_hit_i & ~flags_q.empty;
        wptr_d    = ptr_step(wptr_q, wr_en_o_c);
        // Flush swallows a push accepted in the same cycle.
        rptr_d    = flush_i ? wptr_d : ptr_step(rptr_q, rd_en_o_c);
        count_d   = ptr_count(wptr_d, rptr_d);
        flags_d   = calc_flags(count_d, afull_thresh_i);
        ovf_d     = ~flush_i & (ovf_q | (push_hit_i & flags_q.full));
        udf_d     = ~flush_i & (udf_q | (pop_hit_i & flags_q.empty));
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flags_q <= '{empty: 1'b1, full: 1'b0, afull: 1'b0};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wr_addr_o_c = wptr_q[FIFO_AW-1:0];
    assign rd_addr_o_c = rptr_q[FIFO_AW-1:0];
    assign empty_o     = flags_q.empty;
    assign full_o      = flags_q.full;
    assign afull_o     = flags_q.afull;
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule

// File: rtl/fifo_sync_mc.sv
// Single-clock multi-channel FIFO: C queues of N entries share one
// statically partitioned C*N x W array. One push and one pop per cycle.
// N and C must match the package geometry (pointer type width).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   push, push_chan, push_data      push request, channel, payload
//   pop, pop_chan                   pop request, channel
//   pop_vld_r, pop_chan_r, pop_data pop response, one cycle after accept
//   flush                           per-channel flush
//   afull_thresh                    almost-full threshold, all channels
//   empty_r, full_r, afull_r        per-channel flags
//   count_r                         per-channel occupancy, packed
//   ovf_r, udf_r                    per-channel sticky errors
module fifo_sync_mc
    import fifo_sync_mc_pkg::*;
#(
    parameter  int unsigned W  = FIFO_W,
    parameter  int unsigned N  = FIFO_N,
    parameter  int unsigned C  = FIFO_C,
    localparam int unsigned CW = $clog2(C),
    localparam int unsigned AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [CW-1:0]       push_chan,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    input  logic [CW-1:0]       pop_chan,
    output logic                pop_vld_r,
    output logic [CW-1:0]       pop_chan_r,
    output logic [W-1:0]        pop_data,
    input  logic [C-1:0]        flush,
    input  logic [AW:0]         afull_thresh,
    output logic [C-1:0]        empty_r,
    output logic [C-1:0]        full_r,
    output logic [C-1:0]        afull_r,
    output logic [C*(AW+1)-1:0] count_r,
    output logic [C-1:0]        ovf_r,
    output logic [C-1:0]        udf_r
);

    logic [W-1:0]  mem_q [C*N];

    logic          wr_en_c   [C];
    logic          rd_en_c   [C];
    logic [AW-1:0] wr_addr_c [C];
    logic [AW-1:0] rd_addr_c [C];
    logic          empty_a   [C];
    logic          full_a    [C];
    logic          afull_a   [C];
    logic [AW:0]   count_a   [C];
    logic          ovf_a     [C];
    logic          udf_a     [C];
    logic          wr_sel_c;
    logic          rd_sel_c;

    for (genvar c = 0; c < C; c++) begin : g_chan
        logic push_hit_c;
        logic pop_hit_c;

        assign push_hit_c = push & (push_chan == CW'(c));
        assign pop_hit_c  = pop & (pop_chan == CW'(c));

        fifo_sync_mc_ctrl u_ctrl (
            .clk            (clk),
            .rst_n          (rst_n),
            .push_hit_i     (push_hit_c),
            .pop_hit_i      (pop_hit_c),
            .flush_i        (flush[c]),
            .afull_thresh_i (afull_thresh),
            .wr_en_o_c      (wr_en_c[c]),
            .rd_en_o_c      (rd_en_c[c]),
            .wr_addr_o_c    (wr_addr_c[c]),
            .rd_addr_o_c    (rd_addr_c[c]),
            .empty_o        (empty_a[c]),
            .full_o         (full_a[c]),
            .afull_o        (afull_a[c]),
            .count_o        (count_a[c]),
            .ovf_o          (ovf_a[c]),
            .udf_o          (udf_a[c])
        );
    end

    // Pack per-channel status into the flat output buses.
    always_comb begin
        empty_r = '0;
        full_r  = '0;
        afull_r = '0;
        count_r = '0;
        ovf_r   = '0;
        udf_r   = '0;
        for (int c = 0; c < C; c++) begin
            empty_r[c]              = empty_a[c];
            full_r[c]               = full_a[c];
            afull_r[c]              = afull_a[c];
            count_r[c*(AW+1) +: AW+1] = count_a[c];
            ovf_r[c]                = ovf_a[c];
            udf_r[c]                = udf_a[c];
        end
    end

    assign wr_sel_c = wr_en_c[push_chan];
    assign rd_sel_c = rd_en_c[pop_chan];

    // Shared storage; a same-address read/write can't happen because a
    // full channel drops its push and an empty channel rejects its pop.
    always_ff @(posedge clk) begin
        if (wr_sel_c) begin
            mem_q[{push_chan, wr_addr_c[push_chan]}] <= push_data;
        end
    end

    // Pop response control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_vld_r  <= 1'b0;
            pop_chan_r <= '0;
        end else begin
            pop_vld_r <= rd_sel_c;
            if (rd_sel_c) begin
                pop_chan_r <= pop_chan;
            end
        end
    end

    // Pop payload is not reset.
    always_ff @(posedge clk) begin
        if (rd_sel_c) begin
            pop_data <= mem_q[{pop_chan, rd_addr_c[pop_chan]}];
        end
    end

endmodule
